vga_pattern_gen: RTL and testbench

//   Pixel source directly downstream of the vga timing generator (1440x900@60, 106 MHz).

---
 rtl/vga_pattern_gen_pkg.sv | 37 +++
 rtl/vga_pattern_gen_if.sv | 28 ++
 rtl/vga_pattern_gen_sync_delay.sv | 27 ++
 rtl/vga_pattern_gen.sv | 134 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern source: pattern mode encodings,
// colour-bar palette and geometry constants for checker, grid and scroll patterns.
package vga_pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_BLACK   = 3'd0,
    MODE_WHITE   = 3'd1,
    MODE_BARS    = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_GRID    = 3'd4,
    MODE_RAMP    = 3'd5,
    MODE_SCROLL  = 3'd6,
    MODE_RSVD    = 3'd7
  } mode_e;

  localparam int CHK_BIT     = 5;   // 32x32 checker squares
  localparam int GRID_BITS   = 6;   // grid line every 64 px
  localparam int SCROLL_STEP = 4;
  localparam int SCROLL_LEN  = 16;

  // Bar palette as {r,g,b} on/off flags, left to right.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video bus between timing generator, pattern source and downstream sink:
// timing/coordinate inputs and the delayed syncs plus pixel colour.
interface vga_pattern_gen_if #(
  parameter int W  = 12,
  parameter int CW = 8
);
  logic          hsync_in;
  logic          vsync_in;
  logic          de_in;
  logic [W-1:0]  hdata;
  logic [W-1:0]  vdata;
  logic          hsync_out;
  logic          vsync_out;
  logic          de_out;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;

  modport master (
    output hsync_in, vsync_in, de_in, hdata, vdata,
    input  hsync_out, vsync_out, de_out, r, g, b
  );

  modport slave (
    input  hsync_in, vsync_in, de_in, hdata, vdata,
    output hsync_out, vsync_out, de_out, r, g, b
  );
endinterface

// File: rtl/vga_pattern_gen_sync_delay.sv
// Per-bit shift register with an individual reset value per bit, used to
// keep syncs and control bits aligned with the colour pipeline.
module vga_pattern_gen_sync_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: latches the pattern mode at each frame start and
// produces RGB through a 2-stage pipeline with syncs/de delayed to match.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int   W       = 12,
  parameter int   HRES    = 1440,
  parameter int   VRES    = 900,
  parameter int   CW      = 8,
  parameter logic HS_IDLE = 1'b0,
  parameter logic VS_IDLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_pattern_gen_if.slave    vid,
  input  logic [2:0]          mode,
  input  logic                en,
  output logic [15:0]         frame_cnt
);

  logic          fs;
  mode_e         mode_q, mode_cur;
  logic [W-1:0]  scroll, scroll_nx, scroll_cur;
  logic [W:0]    scroll_inc;
  logic [2:0]    sync_q;
  logic          de_p1, en_p1;
  mode_e         mode_p1;
  logic [2:0]    bar_p1;
  logic          chk_p1, grid_p1, scrl_p1;
  logic [CW-1:0] ramp_p1;
  logic [3*CW-1:0] rgb_p2;

  // Bar index from threshold compares; anything past the last edge lands in bar 7.
  function automatic logic [2:0] bar_idx(input logic [W-1:0] h);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++)
      if (h >= W'(k * HRES / 8)) idx = idx + 3'd1;
    return idx;
  endfunction

  function automatic logic [3*CW-1:0] colour(input mode_e m, input logic [2:0] bar,
                                             input logic chk, input logic grid,
                                             input logic scrl, input logic [CW-1:0] ramp);
    logic [2:0]      on;
    logic [3*CW-1:0] c;
    case (m)
      MODE_WHITE:   on = 3'b111;
      MODE_BARS:    on = bar_rgb(bar);
      MODE_CHECKER: on = {3{chk}};
      MODE_GRID:    on = {3{grid}};
      MODE_SCROLL:  on = {3{scrl}};
      default:      on = 3'b000;
    endcase
    c = {{CW{on[2]}}, {CW{on[1]}}, {CW{on[0]}}};
    if (m == MODE_RAMP) c = {3{ramp}};
    return c;
  endfunction

  // Frame start needs no history, so a frame is never missed after reset.
  assign fs         = vid.de_in && (vid.hdata == '0) && (vid.vdata == '0);
  assign scroll_inc = {1'b0, scroll} + (W+1)'(SCROLL_STEP);
  assign scroll_nx  = (scroll_inc >= (W+1)'(HRES)) ? '0 : scroll_inc[W-1:0];
  assign mode_cur   = fs ? mode_e'(mode) : mode_q;
  assign scroll_cur = fs ? scroll_nx : scroll;

  vga_pattern_gen_sync_delay #(
    .WIDTH(3), .DEPTH(2), .RST_VAL({HS_IDLE, VS_IDLE, 1'b0})
  ) u_sync (
    .clk(clk), .rst_n(rst_n),
    .d({vid.hsync_in, vid.vsync_in, vid.de_in}),
    .q(sync_q)
  );

  vga_pattern_gen_sync_delay #(
    .WIDTH(2), .DEPTH(1), .RST_VAL(2'b00)
  ) u_ctl (
    .clk(clk), .rst_n(rst_n),
    .d({vid.de_in, en}),
    .q({de_p1, en_p1})
  );

  // Frame-level state: updated on FS regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_BLACK;
      scroll    <= '0;
      frame_cnt <= '0;
    end else if (fs) begin
      mode_q    <= mode_e'(mode);
      scroll    <= scroll_nx;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Stage 1: per-pixel pattern features
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p1 <= MODE_BLACK;
      bar_p1  <= '0;
      chk_p1  <= 1'b0;
      grid_p1 <= 1'b0;
      scrl_p1 <= 1'b0;
      ramp_p1 <= '0;
    end else begin
      mode_p1 <= mode_cur;
      bar_p1  <= bar_idx(vid.hdata);
      chk_p1  <= vid.hdata[CHK_BIT] ^ vid.vdata[CHK_BIT];
      grid_p1 <= (vid.hdata[GRID_BITS-1:0] == '0) || (vid.vdata[GRID_BITS-1:0] == '0) ||
                 (vid.hdata == W'(HRES-1)) || (vid.vdata == W'(VRES-1));
      scrl_p1 <= ({1'b0, vid.hdata} >= {1'b0, scroll_cur}) &&
                 ({1'b0, vid.hdata} < ({1'b0, scroll_cur} + (W+1)'(SCROLL_LEN)));
      ramp_p1 <= vid.hdata[CW-1:0];
    end
  end

  // Stage 2: colour mux with blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= '0;
    end else begin
      rgb_p2 <= (de_p1 && en_p1) ? colour(mode_p1, bar_p1, chk_p1, grid_p1, scrl_p1, ramp_p1)
                                 : '0;
    end
  end

  assign vid.hsync_out = sync_q[2];
  assign vid.vsync_out = sync_q[1];
  assign vid.de_out    = sync_q[0];
  assign vid.r         = rgb_p2[3*CW-1 -: CW];
  assign vid.g         = rgb_p2[2*CW-1 -: CW];
  assign vid.b         = rgb_p2[CW-1:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: isolated pixel vectors per mode plus
// sequences for sync alignment, mid-frame mode change, en gating, reset and scroll wrap.
module tb_vga_pattern_gen;
  localparam int W  = 12;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mode;
  logic        en;
  logic [15:0] frame_cnt;

  int nchk = 0;
  int nfail = 0;
  int fs_n = 0;

  vga_pattern_gen_if #(.W(W), .CW(CW)) vif();

  vga_pattern_gen #(
    .W(W), .HRES(1440), .VRES(900), .CW(CW), .HS_IDLE(1'b0), .VS_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vid(vif), .mode(mode), .en(en), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   mode;
    logic         en;
    logic [W-1:0] h;
    logic [W-1:0] v;
    logic [23:0]  rgb;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [2:0] m, input logic e, input int h, input int v,
                              input logic [23:0] c);
    vec_t t;
    t.mode = m; t.en = e; t.h = W'(h); t.v = W'(v); t.rgb = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [W-1:0] h, input logic [W-1:0] v);
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    vif.de_in    = de;
    vif.hdata    = h;
    vif.vdata    = v;
  endtask

  task automatic idle;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic fs;
    drive(1'b0, 1'b1, 1'b1, '0, '0);
    fs_n++;
    tick();
    idle();
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h00, vif.r, vif.g, vif.b};
  endfunction

  // One active pixel followed by blanking; checked when it emerges 2 clk later.
  task automatic px(input int h, input int v, input logic e, input logic [23:0] exp,
                    input string nm);
    en = e;
    drive(1'b0, 1'b1, 1'b1, W'(h), W'(v));
    if (h == 0 && v == 0) fs_n++;
    tick();
    idle();
    en = 1'b1;
    tick();
    chk(nm, {7'b0, vif.de_out, vif.r, vif.g, vif.b}, {7'b0, 1'b1, exp});
  endtask

  logic [2:0] hist [40];

  initial begin
    rst_n = 1'b0;
    mode  = 3'd2;
    en    = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 12'd5, 12'd5);
    tick();
    tick();
    chk("rst_hsync", {31'b0, vif.hsync_out}, 32'd0);
    chk("rst_vsync", {31'b0, vif.vsync_out}, 32'd1);
    chk("rst_de", {31'b0, vif.de_out}, 32'd0);
    chk("rst_rgb", rgb_now(), 32'd0);
    chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    fs_n  = 0;
    idle();
    tick();

    // Before any frame start the output is black regardless of requested mode.
    px(100, 100, 1'b1, 24'h000000, "no_fs_black");

    tv.push_back(mk(3'd0, 1'b1,  500, 300, 24'h000000));
    tv.push_back(mk(3'd1, 1'b1,  500, 300, 24'hFFFFFF));
    tv.push_back(mk(3'd2, 1'b1,  179,  10, 24'hFFFFFF));
    tv.push_back(mk(3'd2, 1'b1,  180,  10, 24'hFFFF00));
    tv.push_back(mk(3'd2, 1'b1,  360,  10, 24'h00FFFF));
    tv.push_back(mk(3'd2, 1'b1,  540,  10, 24'h00FF00));
    tv.push_back(mk(3'd2, 1'b1,  720,  10, 24'hFF00FF));
    tv.push_back(mk(3'd2, 1'b1,  900,  10, 24'hFF0000));
    tv.push_back(mk(3'd2, 1'b1, 1259,  10, 24'h0000FF));
    tv.push_back(mk(3'd2, 1'b1, 1260,  10, 24'h000000));
    tv.push_back(mk(3'd2, 1'b1, 1439,  10, 24'h000000));
    tv.push_back(mk(3'd2, 1'b1, 2000,  10, 24'h000000));
    tv.push_back(mk(3'd3, 1'b1,   32,   0, 24'hFFFFFF));
    tv.push_back(mk(3'd3, 1'b1,   32,  32, 24'h000000));
    tv.push_back(mk(3'd3, 1'b1,    0,  33, 24'hFFFFFF));
    tv.push_back(mk(3'd3, 1'b1,    5,   5, 24'h000000));
    tv.push_back(mk(3'd4, 1'b1,   64,  10, 24'hFFFFFF));
    tv.push_back(mk(3'd4, 1'b1,   65,  10, 24'h000000));
    tv.push_back(mk(3'd4, 1'b1, 1439,  10, 24'hFFFFFF));
    tv.push_back(mk(3'd4, 1'b1,   65, 899, 24'hFFFFFF));
    tv.push_back(mk(3'd4, 1'b1,   65,  64, 24'hFFFFFF));
    tv.push_back(mk(3'd4, 1'b1, 1440,  10, 24'h000000));
    tv.push_back(mk(3'd5, 1'b1,  300,   1, 24'h2C2C2C));
    tv.push_back(mk(3'd5, 1'b1,  255,   7, 24'hFFFFFF));
    tv.push_back(mk(3'd7, 1'b1,   64,  10, 24'h000000));
    tv.push_back(mk(3'd1, 1'b0,   10,  10, 24'h000000));

    for (int i = 0; i < tv.size(); i++) begin
      mode = tv[i].mode;
      fs();
      px(int'(tv[i].h), int'(tv[i].v), tv[i].en, tv[i].rgb, $sformatf("vec%0d", i));
    end
    chk("frame_cnt_table", {16'b0, frame_cnt}, 32'(fs_n));

    // Syncs/de follow inputs by exactly 2 clk; colour blanks with de_out.
    mode = 3'd1;
    px(0, 0, 1'b1, 24'hFFFFFF, "fs_white");
    for (int i = 0; i < 40; i++) begin
      hist[i] = 3'($urandom_range(0, 7));
      drive(hist[i][2], hist[i][1], hist[i][0], 12'd7, 12'd3);
      tick();
      if (i > 0) begin
        chk("sync_delay", {29'b0, vif.hsync_out, vif.vsync_out, vif.de_out}, {29'b0, hist[i-1]});
        chk("blank_rgb", rgb_now(), hist[i-1][0] ? 32'h00FFFFFF : 32'h0);
      end
    end
    idle();

    // Mode change mid-frame takes effect only at the next frame start.
    mode = 3'd3;
    fs();
    mode = 3'd4;
    px(32, 450, 1'b1, 24'hFFFFFF, "midframe_chk_white");
    px(0, 450, 1'b1, 24'h000000, "midframe_chk_black");
    fs();
    px(64, 10, 1'b1, 24'hFFFFFF, "grid_64_10");
    px(65, 10, 1'b1, 24'h000000, "grid_65_10");
    px(1439, 10, 1'b1, 24'hFFFFFF, "grid_1439");

    // en gating by line.
    mode = 3'd1;
    fs();
    px(5,  99, 1'b1, 24'hFFFFFF, "en_line99");
    px(5, 100, 1'b0, 24'h000000, "en_line100");
    px(5, 199, 1'b0, 24'h000000, "en_line199");
    px(5, 200, 1'b1, 24'hFFFFFF, "en_line200");
    en = 1'b0;
    fs();
    en = 1'b1;
    chk("frame_cnt_en0", {16'b0, frame_cnt}, 32'(fs_n));

    // Reset mid-line.
    mode = 3'd1;
    fs();
    drive(1'b1, 1'b0, 1'b1, 12'd10, 12'd10);
    tick();
    tick();
    chk("pre_rst_rgb", rgb_now(), 32'h00FFFFFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", {31'b0, vif.hsync_out}, 32'd0);
    chk("mid_rst_vsync", {31'b0, vif.vsync_out}, 32'd1);
    chk("mid_rst_de", {31'b0, vif.de_out}, 32'd0);
    chk("mid_rst_rgb", rgb_now(), 32'd0);
    chk("mid_rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    fs_n  = 0;
    tick();
    tick();
    chk("post_rst_sync", {29'b0, vif.hsync_out, vif.vsync_out, vif.de_out}, 32'b101);
    chk("post_rst_black", rgb_now(), 32'd0);
    idle();
    px(0, 0, 1'b1, 24'hFFFFFF, "post_rst_fs");
    chk("post_rst_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Scroll animation across the wrap point.
    mode = 3'd6;
    for (int k = 0; k < 358; k++) fs();
    px(1436, 20, 1'b1, 24'hFFFFFF, "scroll_1436");
    px(1451, 20, 1'b1, 24'hFFFFFF, "scroll_1451");
    px(1435, 20, 1'b1, 24'h000000, "scroll_1435");
    px(1452, 20, 1'b1, 24'h000000, "scroll_1452");
    px(0, 0, 1'b1, 24'hFFFFFF, "scroll_wrap_fs");
    px(15, 1, 1'b1, 24'hFFFFFF, "scroll0_15");
    px(16, 1, 1'b1, 24'h000000, "scroll0_16");
    px(0, 0, 1'b1, 24'h000000, "scroll4_fs");
    chk("frame_cnt_361", {16'b0, frame_cnt}, 32'd361);
    px(3, 1, 1'b1, 24'h000000, "scroll4_3");
    px(4, 1, 1'b1, 24'hFFFFFF, "scroll4_4");
    px(19, 1, 1'b1, 24'hFFFFFF, "scroll4_19");
    px(20, 1, 1'b1, 24'h000000, "scroll4_20");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
